// File: rtl/result_bcd_converter_if.sv
// rtl/result_bcd_converter_if.sv - request/result bundle between the arithmetic units, BCD converter and display driver
interface result_bcd_converter_if #(
  parameter int MAG_W  = 17,
  parameter int DIGITS = 6
);

  logic                  start;
  logic [MAG_W:0]        result;
  logic                  busy;
  logic                  done;
  logic                  sign;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;

  // Producer side: issues conversions and observes the display-ready results
  modport master (
    output start,
    output result,
    input  busy,
    input  done,
    input  sign,
    input  bcd,
    input  blank
  );

  // Converter side
  modport slave (
    input  start,
    input  result,
    output busy,
    output done,
    output sign,
    output bcd,
    output blank
  );

endinterface

// File: rtl/result_bcd_converter.sv
// rtl/result_bcd_converter.sv - sequential double-dabble binary-to-BCD converter; optional blanking via RESULT_BCD_LEADING_ZERO_BLANK_EN
module result_bcd_converter #(
  parameter int MAG_W  = 17,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  result_bcd_converter_if.slave bus
);

  localparam int CNT_W = $clog2(MAG_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MAG_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_lat_q, sign_lat_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   acc_adj;
  logic [DIGITS-1:0]  blank_calc;
  logic [MAG_W-1:0]   mag_in;

  assign mag_in = bus.result[MAG_W-1:0];

  // Add-3 correction: every nibble >= 5 gets +3 independently, no inter-nibble carry
  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end else begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4];
      end
    end
  end

`ifdef RESULT_BCD_LEADING_ZERO_BLANK_EN
  // Leading-zero mask from the top digit down; units digit is never blanked so zero shows "0"
  always_comb begin
    logic lead;
    blank_calc = '0;
    lead       = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead          = lead && (acc_q[4*i +: 4] == 4'd0);
      blank_calc[i] = lead;
    end
  end
`else
  // Blanking disabled: mask stays all zeros
  always_comb begin
    blank_calc = '0;
  end
`endif

  // Next-state and datapath: IDLE latches, SHIFT runs one bit per cycle, DONE publishes
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sign_lat_d = sign_lat_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    blank_d    = blank_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shift_d    = mag_in;
          // Negative zero is shown as plain zero
          sign_lat_d = bus.result[MAG_W] & (|mag_in);
          acc_d      = '0;
          cnt_d      = CNT_W'(MAG_W);
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        acc_d   = {acc_adj[BCD_W-2:0], shift_q[MAG_W-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        bcd_d   = acc_q;
        sign_d  = sign_lat_q;
        blank_d = blank_calc;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sign_lat_q <= 1'b0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      blank_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sign_lat_q <= sign_lat_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      blank_q    <= blank_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = done_q;
  assign bus.sign  = sign_q;
  assign bus.bcd   = bcd_q;
  assign bus.blank = blank_q;

endmodule
